// File: rtl/flat_output_byte_serializer_pkg.sv
// Shared constants for the flat-output byte serializer and the ice40 uncore wrappers.
package flat_output_byte_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Byte counter width; a single-byte word still needs a 1-bit counter.
    function automatic int cnt_width(input int num_bytes);
        return (num_bytes <= 1) ? 1 : $clog2(num_bytes);
    endfunction

endpackage

// File: rtl/flat_output_byte_serializer_if.sv
// Upstream word handshake plus downstream tx_byte handshake for the serializer.
interface flat_output_byte_serializer_if #(
    parameter int NumBytes = 4
);
    import flat_output_byte_serializer_pkg::*;

    logic [NumBytes*BYTE_W-1:0] flat_output;
    logic                       flat_output_valid;
    logic                       flat_output_ready;
    logic [BYTE_W-1:0]          tx_byte;
    logic                       tx_byte_valid;
    logic                       tx_byte_ready;
    logic                       busy;

    modport slave (
        input  flat_output, flat_output_valid, tx_byte_ready,
        output flat_output_ready, tx_byte, tx_byte_valid, busy
    );

    modport master (
        output flat_output, flat_output_valid, tx_byte_ready,
        input  flat_output_ready, tx_byte, tx_byte_valid, busy
    );

endinterface

// File: rtl/flat_output_byte_serializer.sv
// Captures one NumBytes-wide result word and streams it out a byte at a time
// to the UART transmitter, with zero-gap back-to-back word acceptance.
module flat_output_byte_serializer
    import flat_output_byte_serializer_pkg::*;
#(
    parameter int NumBytes = 4,
    parameter bit LsbFirst = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    flat_output_byte_serializer_if.slave  bus
);

    localparam int                W    = NumBytes * BYTE_W;
    localparam int                CW   = cnt_width(NumBytes);
    localparam logic [CW-1:0]     LAST = CW'(NumBytes - 1);

    ser_state_e    state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic last_byte;
    logic tx_hs;
    logic in_ready;
    logic in_hs;

    always_comb begin
        last_byte = (cnt_q == LAST);
        tx_hs     = (state_q == SEND) && bus.tx_byte_ready;
        // In SEND the next word is only taken as the final byte leaves.
        in_ready  = (state_q == IDLE) || (last_byte && bus.tx_byte_ready);
        in_hs     = bus.flat_output_valid && in_ready;

        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        if (tx_hs) begin
            shift_d = LsbFirst ? (shift_q >> BYTE_W) : (shift_q << BYTE_W);
            if (last_byte) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A capture overrides the completion path so the stream stays in SEND.
        if (in_hs) begin
            shift_d = bus.flat_output;
            cnt_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        if (LsbFirst) begin : g_lsb
            assign bus.tx_byte = shift_q[BYTE_W-1:0];
        end else begin : g_msb
            assign bus.tx_byte = shift_q[W-1 -: BYTE_W];
        end
    endgenerate

    assign bus.tx_byte_valid     = (state_q == SEND);
    assign bus.busy              = (state_q == SEND);
    assign bus.flat_output_ready = in_ready;

endmodule

// File: tb/tb_flat_output_byte_serializer.sv
// Scoreboard bench: expected bytes are queued at word presentation and popped on each tx handshake.
module tb_flat_output_byte_serializer;
    import flat_output_byte_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flat_output_byte_serializer_if #(.NumBytes(4)) bus_l ();
    flat_output_byte_serializer_if #(.NumBytes(4)) bus_m ();

    flat_output_byte_serializer #(.NumBytes(4), .LsbFirst(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l)
    );
    flat_output_byte_serializer #(.NumBytes(4), .LsbFirst(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    logic       hold_l = 1'b0, hold_m = 1'b0;
    logic [7:0] hold_b_l = '0, hold_b_m = '0;

    // Scoreboard and hold-stability monitors, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n) begin
            if (hold_l) begin
                n_total++;
                if (bus_l.tx_byte_valid === 1'b1 && bus_l.tx_byte === hold_b_l) n_pass++;
                else $display("FAIL hold_l valid=%b byte=%h required valid=1 byte=%h", bus_l.tx_byte_valid, bus_l.tx_byte, hold_b_l);
            end
            if (bus_l.tx_byte_valid && bus_l.tx_byte_ready) begin
                n_total++;
                if (q_l.size() == 0) $display("FAIL sb_l unexpected byte %h, none required", bus_l.tx_byte);
                else begin
                    exp_b = q_l.pop_front();
                    if (bus_l.tx_byte !== exp_b) $display("FAIL sb_l byte %h required %h", bus_l.tx_byte, exp_b);
                    else n_pass++;
                end
            end
            hold_l   = bus_l.tx_byte_valid && !bus_l.tx_byte_ready;
            hold_b_l = bus_l.tx_byte;
        end else hold_l = 1'b0;
    end

    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n) begin
            if (hold_m) begin
                n_total++;
                if (bus_m.tx_byte_valid === 1'b1 && bus_m.tx_byte === hold_b_m) n_pass++;
                else $display("FAIL hold_m valid=%b byte=%h required valid=1 byte=%h", bus_m.tx_byte_valid, bus_m.tx_byte, hold_b_m);
            end
            if (bus_m.tx_byte_valid && bus_m.tx_byte_ready) begin
                n_total++;
                if (q_m.size() == 0) $display("FAIL sb_m unexpected byte %h, none required", bus_m.tx_byte);
                else begin
                    exp_b = q_m.pop_front();
                    if (bus_m.tx_byte !== exp_b) $display("FAIL sb_m byte %h required %h", bus_m.tx_byte, exp_b);
                    else n_pass++;
                end
            end
            hold_m   = bus_m.tx_byte_valid && !bus_m.tx_byte_ready;
            hold_b_m = bus_m.tx_byte;
        end else hold_m = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lsb(input logic [31:0] w);
        for (int i = 0; i < 4; i++) q_l.push_back(w[i*8 +: 8]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus_l.tx_byte_valid !== 1'b0) $display("FAIL rst_valid got %b required 0", bus_l.tx_byte_valid); else n_pass++;
        n_total++; if (bus_l.flat_output_ready !== 1'b1) $display("FAIL rst_ready got %b required 1", bus_l.flat_output_ready); else n_pass++;
        n_total++; if (bus_l.busy !== 1'b0) $display("FAIL rst_busy got %b required 0", bus_l.busy); else n_pass++;
        n_total++; if (bus_l.tx_byte !== 8'h00) $display("FAIL rst_byte got %h required 00", bus_l.tx_byte); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_total++; if (bus_l.busy !== 1'b0 || bus_l.tx_byte_valid !== 1'b0) $display("FAIL idle_busy got busy=%b valid=%b required 0/0", bus_l.busy, bus_l.tx_byte_valid); else n_pass++;
        n_total++; if (bus_m.flat_output_ready !== 1'b1) $display("FAIL idle_ready_m got %b required 1", bus_m.flat_output_ready); else n_pass++;
    endtask

    task automatic test_lsb_stream();
        int cyc;
        bus_l.tx_byte_ready = 1'b1;
        bus_l.flat_output = 32'h56575859;
        bus_l.flat_output_valid = 1'b1;
        push_lsb(32'h56575859);
        step();
        bus_l.flat_output_valid = 1'b0;
        n_total++; if (bus_l.tx_byte_valid !== 1'b1 || bus_l.tx_byte !== 8'h59) $display("FAIL lsb_first valid=%b byte=%h required 1/59", bus_l.tx_byte_valid, bus_l.tx_byte); else n_pass++;
        n_total++; if (bus_l.busy !== 1'b1) $display("FAIL lsb_busy got %b required 1", bus_l.busy); else n_pass++;
        cyc = 0;
        while (bus_l.busy && cyc < 20) begin step(); cyc++; end
        n_total++; if (cyc != 4) $display("FAIL lsb_cycles got %0d required 4", cyc); else n_pass++;
        n_total++; if (q_l.size() != 0) $display("FAIL lsb_drain left %0d required 0", q_l.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        bus_l.tx_byte_ready = 1'b0;
        bus_l.flat_output = 32'h56575859;
        bus_l.flat_output_valid = 1'b1;
        push_lsb(32'h56575859);
        step();
        bus_l.flat_output_valid = 1'b0;
        cyc = 0;
        while ((bus_l.busy || q_l.size() != 0) && cyc < 60) begin
            bus_l.tx_byte_ready = (cyc % 3 == 2);
            step();
            cyc++;
        end
        n_total++; if (cyc >= 60 || q_l.size() != 0) $display("FAIL bp_drain left %0d cycles %0d required 0 within 60", q_l.size(), cyc); else n_pass++;
        n_total++; if (cyc != 12) $display("FAIL bp_cycles got %0d required 12", cyc); else n_pass++;
        bus_l.tx_byte_ready = 1'b1;
    endtask

    task automatic test_msb();
        int cyc;
        bus_m.tx_byte_ready = 1'b1;
        bus_m.flat_output = 32'hA1B2C3D4;
        bus_m.flat_output_valid = 1'b1;
        q_m.push_back(8'hA1); q_m.push_back(8'hB2); q_m.push_back(8'hC3); q_m.push_back(8'hD4);
        step();
        bus_m.flat_output_valid = 1'b0;
        n_total++; if (bus_m.tx_byte !== 8'hA1) $display("FAIL msb_first byte %h required a1", bus_m.tx_byte); else n_pass++;
        cyc = 0;
        while ((bus_m.busy || q_m.size() != 0) && cyc < 20) begin step(); cyc++; end
        n_total++; if (cyc != 4 || q_m.size() != 0) $display("FAIL msb_drain cycles %0d left %0d required 4/0", cyc, q_m.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus_l.tx_byte_ready = 1'b1;
        bus_l.flat_output = 32'h56575859;
        bus_l.flat_output_valid = 1'b1;
        push_lsb(32'h56575859);
        push_lsb(32'h11223344);
        step();
        // Second word offered immediately; it must wait for the last-byte handshake.
        bus_l.flat_output = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (bus_l.flat_output_ready !== 1'b0) $display("FAIL b2b_midword_ready idx %0d got %b required 0", i, bus_l.flat_output_ready); else n_pass++;
            step();
        end
        n_total++; if (bus_l.flat_output_ready !== 1'b1 || bus_l.tx_byte !== 8'h56) $display("FAIL b2b_last_ready got %b byte %h required 1/56", bus_l.flat_output_ready, bus_l.tx_byte); else n_pass++;
        step();
        bus_l.flat_output_valid = 1'b0;
        n_total++; if (bus_l.busy !== 1'b1 || bus_l.tx_byte !== 8'h44) $display("FAIL b2b_nogap busy=%b byte=%h required 1/44", bus_l.busy, bus_l.tx_byte); else n_pass++;
        cyc = 0;
        while ((bus_l.busy || q_l.size() != 0) && cyc < 20) begin step(); cyc++; end
        n_total++; if (cyc != 4 || q_l.size() != 0) $display("FAIL b2b_drain cycles %0d left %0d required 4/0", cyc, q_l.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus_l.tx_byte_ready = 1'b1;
        bus_l.flat_output = 32'h56575859;
        bus_l.flat_output_valid = 1'b1;
        q_l.push_back(8'h59); q_l.push_back(8'h58);
        step();
        bus_l.flat_output_valid = 1'b0;
        step();
        step();
        // Two bytes handed off; byte 0x57 is on the bus when reset hits.
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus_l.tx_byte_valid !== 1'b0 || bus_l.busy !== 1'b0) $display("FAIL rmid_drop valid=%b busy=%b required 0/0", bus_l.tx_byte_valid, bus_l.busy); else n_pass++;
        n_total++; if (q_l.size() != 0) $display("FAIL rmid_sent left %0d required 0", q_l.size()); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_total++; if (bus_l.tx_byte_valid !== 1'b0) $display("FAIL rmid_quiet valid=%b required 0", bus_l.tx_byte_valid); else n_pass++;
        bus_l.flat_output = 32'h01020304;
        bus_l.flat_output_valid = 1'b1;
        push_lsb(32'h01020304);
        step();
        bus_l.flat_output_valid = 1'b0;
        cyc = 0;
        while ((bus_l.busy || q_l.size() != 0) && cyc < 20) begin step(); cyc++; end
        n_total++; if (cyc != 4 || q_l.size() != 0) $display("FAIL rmid_next cycles %0d left %0d required 4/0", cyc, q_l.size()); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_l.flat_output = '0; bus_l.flat_output_valid = 1'b0; bus_l.tx_byte_ready = 1'b0;
        bus_m.flat_output = '0; bus_m.flat_output_valid = 1'b0; bus_m.tx_byte_ready = 1'b0;
        test_reset();
        test_lsb_stream();
        test_backpressure();
        test_msb();
        test_back_to_back();
        test_reset_mid();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
